// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin two-port arbiter that sequences single-byte SPI master transfers
// with a txc-edge completion, a timeout abort and an idle gap between transactions.
module spi_txn_arbiter #(
  parameter int DATA    = 8,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7,
  parameter int GAP     = 2
) (
  input  logic            i_clk,
  input  logic            i_preset,
  input  logic            i_req0,
  input  logic            i_req1,
  input  logic [DATA-1:0] i_wdata0,
  input  logic [DATA-1:0] i_wdata1,
  input  logic [2:0]      i_cfg0,
  input  logic [2:0]      i_cfg1,
  input  logic            i_txc,
  input  logic [DATA-1:0] i_m_rdata_in,
  output logic            o_gnt0,
  output logic            o_gnt1,
  output logic            o_done0,
  output logic            o_done1,
  output logic [DATA-1:0] o_rdata,
  output logic            o_err,
  output logic            o_busy,
  output logic            o_spe,
  output logic            o_m_wr_rdbar,
  output logic            o_master_control,
  output logic [DATA-1:0] o_m_wdata,
  output logic [2:0]      o_m_addr
);
  localparam int GW = $clog2(GAP + 2);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t        r_state;
  logic          r_lp, r_own, r_txc_d, r_spe;
  logic [TW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic          w_any, w_pick1, w_edge, w_tmo;
  assign w_any   = i_req0 | i_req1;
  // on a tie the port that did not win last time gets the grant
  assign w_pick1 = i_req1 & (~i_req0 | ~r_lp);
  assign w_edge  = i_txc & ~r_txc_d;
  assign w_tmo   = r_cnt == TW'(TIMEOUT - 1);
  assign o_spe            = r_spe;
  assign o_m_wr_rdbar     = r_spe;
  assign o_master_control = r_spe;
  always_ff @(posedge i_clk or posedge i_preset) begin
    if (i_preset) begin
      r_state   <= IDLE;
      r_lp      <= 1'b1;
      r_own     <= 1'b0;
      r_txc_d   <= 1'b0;
      r_spe     <= 1'b0;
      r_cnt     <= '0;
      r_gap     <= '0;
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_done0   <= 1'b0;
      o_done1   <= 1'b0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
      o_m_wdata <= '0;
      o_m_addr  <= '0;
    end else begin
      o_gnt0  <= 1'b0;
      o_gnt1  <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_gap != '0) begin
            r_gap  <= r_gap - GW'(1);
            o_busy <= r_gap != GW'(1);
          end else if (w_any) begin
            r_own     <= w_pick1;
            r_lp      <= w_pick1;
            o_gnt0    <= ~w_pick1;
            o_gnt1    <= w_pick1;
            o_m_wdata <= w_pick1 ? i_wdata1 : i_wdata0;
            o_m_addr  <= w_pick1 ? i_cfg1 : i_cfg0;
            r_spe     <= 1'b1;
            o_busy    <= 1'b1;
            r_state   <= ARM;
          end else begin
            o_busy <= 1'b0;
          end
        end
        ARM: begin
          r_cnt   <= '0;
          r_txc_d <= i_txc;
          r_state <= RUN;
        end
        RUN: begin
          r_txc_d <= i_txc;
          r_cnt   <= r_cnt + TW'(1);
          // a completing txc edge beats a timeout landing in the same cycle
          if (w_edge || w_tmo) begin
            o_rdata <= w_edge ? i_m_rdata_in : '0;
            o_err   <= ~w_edge;
            o_done0 <= ~r_own;
            o_done1 <= r_own;
            r_spe   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_gap   <= GW'(GAP);
          o_busy  <= GAP != 0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed and randomized transactions checked against a cycle-level
// transaction model of grant order, grant timing, completion timing and returned data.
module tb_spi_txn_arbiter;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;
  logic       clk = 1'b0, preset = 1'b1;
  logic       req0 = 0, req1 = 0, txc = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0, m_rdata_in = 0;
  logic [2:0] cfg0 = 0, cfg1 = 0;
  logic       gnt0, gnt1, done0, done1, err, busy, spe, m_wr_rdbar, master_control;
  logic [7:0] rdata, m_wdata;
  logic [2:0] m_addr;
  int  cyc = 0, ntot = 0, npass = 0;
  int  last_done = -1000;
  bit  m_lp = 1'b1;

  spi_txn_arbiter #(.DATA(8), .TIMEOUT(TIMEOUT), .TW(7), .GAP(GAP)) dut (
    .i_clk(clk), .i_preset(preset), .i_req0(req0), .i_req1(req1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .i_cfg0(cfg0), .i_cfg1(cfg1),
    .i_txc(txc), .i_m_rdata_in(m_rdata_in),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_rdata(rdata), .o_err(err), .o_busy(busy), .o_spe(spe),
    .o_m_wr_rdbar(m_wr_rdbar), .o_master_control(master_control),
    .o_m_wdata(m_wdata), .o_m_addr(m_addr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One transaction: k = cycles after the grant cycle at which txc rises (k > TIMEOUT never rises
  // in time); stale holds txc high across ARM and the first RUN cycle.
  task automatic txn(input bit r0, input bit r1, input logic [7:0] wd0, input logic [7:0] wd1,
                     input logic [2:0] c0, input logic [2:0] c1, input logic [7:0] rd,
                     input int k, input bit stale);
    bit win;
    int exp_g, g, exp_d, n;
    req0 = r0; req1 = r1; wdata0 = wd0; wdata1 = wd1; cfg0 = c0; cfg1 = c1;
    m_rdata_in = rd; txc = 1'b0;
    win   = (r0 && r1) ? ~m_lp : r1;
    exp_g = (cyc + 1 > last_done + GAP + 2) ? cyc + 1 : last_done + GAP + 2;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (gnt0 || gnt1 || n >= 200) break;
    end
    g = cyc;
    chk("gnt_cycle", g, exp_g);
    chk("gnt0", gnt0, !win);
    chk("gnt1", gnt1, win);
    chk("m_wdata", m_wdata, win ? wd1 : wd0);
    chk("m_addr", m_addr, win ? c1 : c0);
    chk("spe_arm", {spe, m_wr_rdbar, master_control}, 3'b111);
    chk("busy_arm", busy, 1);
    m_lp  = win;
    exp_d = g + ((k < TIMEOUT) ? k : TIMEOUT) + 1;
    txc   = stale;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (cyc == exp_d || n > TIMEOUT + 10) break;
      chk("spe_run", {spe, m_wr_rdbar, master_control}, 3'b111);
      chk("no_early_done", {done0, done1, gnt0, gnt1}, 0);
      txc = (stale && cyc - g <= 1) || (cyc - g >= k);
      n++;
    end
    chk("done_cycle", cyc, exp_d);
    chk("done0", done0, !win);
    chk("done1", done1, win);
    chk("rdata", rdata, (k <= TIMEOUT) ? rd : 8'h00);
    chk("err", err, k > TIMEOUT);
    chk("spe_done", {spe, m_wr_rdbar, master_control, gnt0, gnt1}, 0);
    chk("m_wdata_hold", m_wdata, win ? wd1 : wd0);
    last_done = cyc;
    txc = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    int k;
    bit r0, r1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {gnt0, gnt1, done0, done1, err, busy, spe, m_wr_rdbar, master_control}, 0);
    chk("rst_data", {rdata, m_wdata, m_addr}, 0);
    preset = 1'b0;
    txn(1, 0, 8'hA5, 8'h00, 3'b100, 3'b000, 8'h3C, 9, 0);
    for (int j = 1; j <= GAP + 1; j++) begin
      @(negedge clk);
      chk("busy_gap", busy, j <= GAP);
    end
    for (int i = 0; i < 4; i++)
      txn(1, 1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom_range(20, 1), 0);
    txn(0, 1, $urandom, $urandom, $urandom, $urandom, $urandom, TIMEOUT + 100, 0);
    txn(0, 1, $urandom, $urandom, $urandom, $urandom, $urandom, 5, 0);
    txn(1, 0, $urandom, $urandom, $urandom, $urandom, 8'h5A, TIMEOUT, 0);
    txn(1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, TIMEOUT + 1, 0);
    txn(0, 1, $urandom, $urandom, $urandom, $urandom, $urandom, 12, 1);
    for (int i = 0; i < 20; i++) begin
      r0 = $urandom; r1 = $urandom;
      if (!r0 && !r1) r0 = 1'b1;
      k = ($urandom_range(3, 0) == 0) ? $urandom_range(TIMEOUT + 2, TIMEOUT - 2) : $urandom_range(25, 1);
      txn(r0, r1, $urandom, $urandom, $urandom, $urandom, $urandom, k, (k >= 3) && $urandom_range(1, 0) == 1);
    end
    repeat (GAP + 2) @(negedge clk);
    req0 = 1'b1; wdata0 = 8'h77; cfg0 = 3'b011;
    @(negedge clk);
    chk("rst_pre_gnt", gnt0, 1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_spe", spe, 1);
    preset = 1'b1;
    #1;
    chk("rst_mid_outs", {gnt0, gnt1, done0, done1, err, busy, spe, m_wr_rdbar, master_control}, 0);
    chk("rst_mid_data", {rdata, m_wdata, m_addr}, 0);
    @(negedge clk);
    chk("rst_no_done", {done0, done1}, 0);
    preset = 1'b0;
    m_lp = 1'b1;
    last_done = -1000;
    txn(1, 1, $urandom, $urandom, $urandom, $urandom, $urandom, 4, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Two-port transaction arbiter and sequencer in front of the SPI master. It accepts single-byte transfer requests from two requesters, grants one at a time with round-robin fairness, and drives the SPI master's enable, direction and configuration inputs. It waits for the master's transfer-complete flag and returns the received byte to the owning requester. A timeout guards against a stalled transfer, and a programmable idle gap separates back-to-back transactions.

## Interface
- data, 8, transfer data width
- timeout, 64, maximum RUN cycles before abort
- tw, 7, width of timeout counter (must hold timeout)
- gap, 2, idle cycles enforced after each transaction

- clk  in  1  system clock (same clock as SPI master)
- preset  in  1  asynchronous, active-high reset
- req0, req1  in  1  transfer request, level, sampled only in IDLE
- wdata0, wdata1  in  data  byte to transmit
- cfg0, cfg1  in  3  bit0 cpole, bit1 cphase, bit2 slave select (0 = ss0, 1 = ss1)
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, wdata/cfg captured
- done0, done1  out  1  one-cycle pulse: transaction finished, rdata/err valid
- rdata  out  data  received byte, held until next done
- err  out  1  asserted with done when the transaction timed out
- busy  out  1  high when state≠IDLE or gap counter≠0
- spe, m_wr_rdbar, master_control  out  1  SPI master enable / write / control
- m_wdata  out  data  captured write byte
- m_addr  out  3  captured cfg
- txc  in  1  SPI master transfer complete
- m_rdata_in  in  data  SPI master read data

## Operation
- States: IDLE, ARM, RUN, DONE. All outputs registered.
- Reset (async, preset=1): state IDLE. All outputs 0, including rdata, m_wdata and m_addr. Last-grant pointer lp=1, so req0 wins the first tie. Gap counter 0, txc_d 0.
- IDLE:
  - Gap counter decrements to 0.
  - With gap=0, arbitration:
    - Only reqX high → grant X.
    - Both high → grant the port ≠ lp.
  - On grant: capture wdata/cfg into m_wdata/m_addr, pulse gntX, record owner, set lp=owner, go ARM.
- ARM (1 cycle): spe=m_wr_rdbar=master_control=1, timeout counter cleared, txc_d loaded with txc.
- RUN:
  - spe/m_wr_rdbar/master_control stay 1; the counter increments each cycle.
  - txc rising edge (txc=1, txc_d=0): rdata←m_rdata_in, err←0, go DONE.
  - Else counter = timeout-1: rdata←0, err←1, go DONE.
  - If a txc edge and the timeout occur in the same cycle, the txc edge wins (err=0).
- DONE (1 cycle):
  - spe/m_wr_rdbar/master_control=0; doneOwner=1.
  - Gap counter loaded with gap; go IDLE.
  - m_wdata/m_addr hold their values until the next grant.
- Requests are ignored outside IDLE. A requester still high after its own done is re-arbitrated normally; if the other port is also requesting, it loses the tie.
- gap=0 allows a grant in the first IDLE cycle after DONE.
- Reset mid-transaction: spe drops immediately, no done pulse, pointer returns to lp=1.

## Timing
- req high at edge N (IDLE, gap 0) → gnt and ARM in cycle N+1, RUN from N+2.
- txc edge seen at edge M → done/rdata visible in cycle M+1.
- Timeout: DONE in cycle N+2+timeout (err=1).
- Minimum request-to-request spacing: 3 + (transfer length) + gap cycles.
- gntX and doneX never overlap. At most one of gnt0/gnt1/done0/done1 is high per cycle.

## Test plan
- Reset: preset=1 mid-RUN → spe=0, gnt/done/err=0, rdata=0 in the same cycle. After release, req0 & req1 together → gnt0 first.
- Single transfer: req0, wdata0=0xA5, cfg0=3'b100; model returns txc after 9 cycles with m_rdata_in=0x3C. Required: m_addr=3'b100, m_wdata=0xA5, done0 with rdata=0x3C, err=0, and spe high exactly ARM..RUN.
- Round robin: req0 and req1 held high for 4 transactions → grants alternate 0,1,0,1, with ≥gap idle cycles between DONE and the next gnt.
- Timeout: req1 with txc tied 0 → done1 with err=1, rdata=0 exactly at cycle N+2+timeout; next request proceeds normally.
- Collision: txc edge on the same cycle the counter reaches timeout-1 → err=0 and rdata=m_rdata_in.
- txc already high at ARM (stale) → no completion until txc falls and rises again.
